// File: rtl/mem_fwd_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mem_fwd_pkg
//  Purpose   : Shared widths, entry type and sizing helpers for the
//              load-to-store forwarding buffer.
//  Revision  : 1.0  initial release
// ============================================================================
package mem_fwd_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } fwd_entry_t;

    // Age 0 is reserved for the same-cycle WB result, so entries need depth+1 codes.
    function automatic int age_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_fwd_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_fwd_buffer_if
//  Purpose   : WB/EX/MEM pipeline signals of the forwarding buffer; the
//              hit counter port exists only when MEM_FWD_STATS_EN is defined.
//  Revision  : 1.0  initial release
// ============================================================================
interface mem_fwd_buffer_if
    import mem_fwd_pkg::*;
#(
    parameter int DATA_W = mem_fwd_pkg::DATA_W,
    parameter int REG_W  = mem_fwd_pkg::REG_W,
    parameter int DEPTH  = 4
);
    localparam int c_AGE_W = age_width(DEPTH);

    logic              wb_reg_write;
    logic              wb_mem_read;
    logic [REG_W-1:0]  wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              ex_mem_write;
    logic [REG_W-1:0]  ex_rt;
    logic              stall;
    logic              flush;
    logic              mem_fwd_sel;
    logic [DATA_W-1:0] mem_fwd_data;
    logic [c_AGE_W-1:0] mem_fwd_age;
`ifdef MEM_FWD_STATS_EN
    logic [31:0]       fwd_hit_count;

    modport master (
        output wb_reg_write, wb_mem_read, wb_dst, wb_data,
        output ex_mem_write, ex_rt, stall, flush,
        input  mem_fwd_sel, mem_fwd_data, mem_fwd_age, fwd_hit_count
    );

    modport slave (
        input  wb_reg_write, wb_mem_read, wb_dst, wb_data,
        input  ex_mem_write, ex_rt, stall, flush,
        output mem_fwd_sel, mem_fwd_data, mem_fwd_age, fwd_hit_count
    );
`else
    modport master (
        output wb_reg_write, wb_mem_read, wb_dst, wb_data,
        output ex_mem_write, ex_rt, stall, flush,
        input  mem_fwd_sel, mem_fwd_data, mem_fwd_age
    );

    modport slave (
        input  wb_reg_write, wb_mem_read, wb_dst, wb_data,
        input  ex_mem_write, ex_rt, stall, flush,
        output mem_fwd_sel, mem_fwd_data, mem_fwd_age
    );
`endif

endinterface
`default_nettype wire

// File: rtl/mem_fwd_buffer_match.sv
`default_nettype none
// ============================================================================
//  Module    : mem_fwd_match
//  Purpose   : Combinational priority matcher; reports the lowest-index
//              (newest) valid entry whose destination equals the key.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_fwd_match
    import mem_fwd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REG_W = mem_fwd_pkg::REG_W,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  wire logic [DEPTH-1:0]            i_valid,
    input  wire logic [DEPTH-1:0][REG_W-1:0] i_dst,
    input  wire logic [REG_W-1:0]            i_key,
    output logic                             o_hit,
    output logic [IDX_W-1:0]                 o_idx
);

    // Scanning oldest to newest lets the newest match overwrite older ones.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_dst[i] == i_key)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_fwd_buffer.sv
`default_nettype none
// ============================================================================
//  Module    : mem_fwd_buffer
//  Purpose   : Retains the DEPTH newest WB load results and forwards them to
//              stores in EX, registered into MEM. Define MEM_FWD_STATS_EN to
//              add the saturating fwd_hit_count output.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_fwd_buffer
    import mem_fwd_pkg::*;
#(
    parameter int DATA_W = mem_fwd_pkg::DATA_W,
    parameter int REG_W  = mem_fwd_pkg::REG_W,
    parameter int DEPTH  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_fwd_buffer_if.slave  bus
);

    localparam int c_AGE_W = age_width(DEPTH);
    localparam int c_IDX_W = idx_width(DEPTH);

    fwd_entry_t                  r_entries     [DEPTH];
    fwd_entry_t                  w_entries_nxt [DEPTH];
    logic [DEPTH-1:0]            w_valid_vec;
    logic [DEPTH-1:0][REG_W-1:0] w_dst_vec;

    logic               w_wb_active;
    logic               w_q_active;
    logic               w_wb_match;
    logic               w_q_hit;
    logic [c_IDX_W-1:0] w_q_idx;
    logic               w_inv_hit;
    logic [c_IDX_W-1:0] w_inv_idx;

    logic               w_sel;
    logic [DATA_W-1:0]  w_data;
    logic [c_AGE_W-1:0] w_age;

    logic               r_sel;
    logic [DATA_W-1:0]  r_data;
    logic [c_AGE_W-1:0] r_age;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_vec[i] = r_entries[i].valid;
            w_dst_vec[i]   = r_entries[i].dst;
        end
    end

    assign w_wb_active = bus.wb_reg_write && (bus.wb_dst != ZERO_REG);
    assign w_q_active  = bus.ex_mem_write && (bus.ex_rt != ZERO_REG);
    assign w_wb_match  = w_wb_active && (bus.wb_dst == bus.ex_rt);

    mem_fwd_match #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .IDX_W (c_IDX_W)
    ) u_query_match (
        .i_valid (w_valid_vec),
        .i_dst   (w_dst_vec),
        .i_key   (bus.ex_rt),
        .o_hit   (w_q_hit),
        .o_idx   (w_q_idx)
    );

    // Every write clears older copies of its dst, so at most one valid entry
    // per register exists and the newest match is the only one to invalidate.
    mem_fwd_match #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .IDX_W (c_IDX_W)
    ) u_inv_match (
        .i_valid (w_valid_vec),
        .i_dst   (w_dst_vec),
        .i_key   (bus.wb_dst),
        .o_hit   (w_inv_hit),
        .o_idx   (w_inv_idx)
    );

    always_comb begin
        w_entries_nxt = r_entries;
        if (w_wb_active) begin
            if (bus.wb_mem_read) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    w_entries_nxt[i] = r_entries[i-1];
                    if (w_inv_hit && (w_inv_idx == c_IDX_W'(i - 1))) begin
                        w_entries_nxt[i].valid = 1'b0;
                    end
                end
                w_entries_nxt[0].valid = 1'b1;
                w_entries_nxt[0].dst   = bus.wb_dst;
                w_entries_nxt[0].data  = bus.wb_data;
            end else if (w_inv_hit) begin
                w_entries_nxt[w_inv_idx].valid = 1'b0;
            end
        end
    end

    // A same-cycle non-load write to ex_rt is a miss even if an older load is
    // buffered: the regular ALU forwarding path owns that value.
    always_comb begin
        w_sel  = 1'b0;
        w_data = '0;
        w_age  = '0;
        if (w_q_active) begin
            if (w_wb_match) begin
                if (bus.wb_mem_read) begin
                    w_sel  = 1'b1;
                    w_data = bus.wb_data;
                end
            end else if (w_q_hit) begin
                w_sel  = 1'b1;
                w_data = r_entries[w_q_idx].data;
                w_age  = c_AGE_W'(w_q_idx) + c_AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_sel  <= 1'b0;
            r_data <= '0;
            r_age  <= '0;
        end else begin
            r_entries <= w_entries_nxt;
            if (bus.flush) begin
                r_sel  <= 1'b0;
                r_data <= '0;
                r_age  <= '0;
            end else if (!bus.stall) begin
                r_sel  <= w_sel;
                r_data <= w_data;
                r_age  <= w_age;
            end
        end
    end

    assign bus.mem_fwd_sel  = r_sel;
    assign bus.mem_fwd_data = r_data;
    assign bus.mem_fwd_age  = r_age;

`ifdef MEM_FWD_STATS_EN
    logic [31:0] r_hit_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count <= '0;
        end else if (!bus.stall && !bus.flush && w_sel && (r_hit_count != '1)) begin
            r_hit_count <= r_hit_count + 32'd1;
        end
    end

    assign bus.fwd_hit_count = r_hit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_fwd_buffer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_fwd_buffer
//  Purpose   : Directed and randomized self-checking bench for mem_fwd_buffer
//              against a write-history reference model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_mem_fwd_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        bit          is_load;
        logic [4:0]  dst;
        logic [31:0] data;
    } wb_ev_t;

    logic clk;
    logic rst_n;

    mem_fwd_buffer_if #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH)) bus_if ();

    mem_fwd_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    wb_ev_t      hist[$];
    bit          exp_sel;
    logic [31:0] exp_data;
    logic [2:0]  exp_age;
    logic [31:0] exp_cnt;

    task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    task automatic check_model(input string tag);
        check1({tag, ".sel"},  32'(bus_if.mem_fwd_sel),  32'(exp_sel));
        check1({tag, ".data"}, bus_if.mem_fwd_data,      exp_data);
        check1({tag, ".age"},  32'(bus_if.mem_fwd_age),  32'(exp_age));
`ifdef MEM_FWD_STATS_EN
        check1({tag, ".cnt"},  bus_if.fwd_hit_count,     exp_cnt);
`endif
    endtask

    task automatic check_const(input string tag, input bit s, input logic [31:0] d, input logic [2:0] a);
        check1({tag, ".sel"},  32'(bus_if.mem_fwd_sel), 32'(s));
        check1({tag, ".data"}, bus_if.mem_fwd_data,     d);
        check1({tag, ".age"},  32'(bus_if.mem_fwd_age), 32'(a));
    endtask

    // The newest write to rt decides: a load still among the DEPTH newest
    // loads hits with its load rank as age; anything else misses.
    task automatic model_query(input bit wr, input bit mr, input logic [4:0] dst,
                               input logic [31:0] data, input bit st, input logic [4:0] rt,
                               output bit sel, output logic [31:0] d, output logic [2:0] age);
        int rank;
        sel = 1'b0; d = '0; age = '0;
        if (st && rt != 5'd0) begin
            if (wr && dst == rt) begin
                if (mr) begin sel = 1'b1; d = data; end
            end else begin
                rank = 0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i].is_load) rank++;
                    if (hist[i].dst == rt) begin
                        if (hist[i].is_load && rank <= DEPTH) begin
                            sel = 1'b1; d = hist[i].data; age = 3'(rank);
                        end
                        break;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit wr, input bit mr, input logic [4:0] dst, input logic [31:0] data,
                         input bit st, input logic [4:0] rt, input bit stl, input bit fl);
        bit          q_sel;
        logic [31:0] q_data;
        logic [2:0]  q_age;
        bus_if.wb_reg_write = wr;
        bus_if.wb_mem_read  = mr;
        bus_if.wb_dst       = dst;
        bus_if.wb_data      = data;
        bus_if.ex_mem_write = st;
        bus_if.ex_rt        = rt;
        bus_if.stall        = stl;
        bus_if.flush        = fl;
        model_query(wr, mr, dst, data, st, rt, q_sel, q_data, q_age);
        @(posedge clk);
        if (fl) begin
            exp_sel = 1'b0; exp_data = '0; exp_age = '0;
        end else if (!stl) begin
            exp_sel = q_sel; exp_data = q_data; exp_age = q_age;
            if (q_sel && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        end
        if (wr && dst != 5'd0) hist.push_back('{is_load: mr, dst: dst, data: data});
        #1;
        check_model("cyc");
    endtask

    task automatic idle_inputs();
        bus_if.wb_reg_write = 1'b0; bus_if.wb_mem_read = 1'b0;
        bus_if.wb_dst = '0; bus_if.wb_data = '0;
        bus_if.ex_mem_write = 1'b0; bus_if.ex_rt = '0;
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        exp_sel = 1'b0; exp_data = '0; exp_age = '0; exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        cycle(0, 0, 5'd0, 32'h0, 1, 5'd8, 0, 0);
        check_const("empty_rt8", 1'b0, 32'h0, 3'd0);

        cycle(1, 1, 5'd8, 32'hDEAD_BEEF, 1, 5'd8, 0, 0);
        check_const("same_cycle", 1'b1, 32'hDEAD_BEEF, 3'd0);

        cycle(1, 1, 5'd9,  32'h11, 0, 5'd0, 0, 0);
        cycle(1, 1, 5'd10, 32'h22, 0, 5'd0, 0, 0);
        cycle(1, 1, 5'd9,  32'h33, 0, 5'd0, 0, 0);
        cycle(0, 0, 5'd0,  32'h0,  1, 5'd9, 0, 0);
        check_const("newest_r9", 1'b1, 32'h33, 3'd1);

        cycle(1, 1, 5'd5, 32'h55,  0, 5'd0, 0, 0);
        cycle(1, 0, 5'd5, 32'h999, 0, 5'd0, 0, 0);
        cycle(0, 0, 5'd0, 32'h0,   1, 5'd5, 0, 0);
        check_const("alu_supersede", 1'b0, 32'h0, 3'd0);

        for (int r = 1; r <= 5; r++) cycle(1, 1, 5'(r), 32'h100 + 32'(r), 0, 5'd0, 0, 0);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd1, 0, 0);
        check_const("dropped_r1", 1'b0, 32'h0, 3'd0);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd2, 0, 0);
        check_const("oldest_r2", 1'b1, 32'h102, 3'd4);

        cycle(1, 1, 5'd7, 32'h77, 1, 5'd7, 1, 0);
        check_const("stall_hold", 1'b1, 32'h102, 3'd4);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 1);
        check_const("flush_stall", 1'b0, 32'h0, 3'd0);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd7, 0, 0);
        check_const("update_in_stall", 1'b1, 32'h77, 3'd1);

        cycle(1, 1, 5'd0, 32'hABCD, 0, 5'd0, 0, 0);
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 0);
        check_const("r0_ignored", 1'b0, 32'h0, 3'd0);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                cycle(0, 0, 5'd0, 32'h0, 1, 5'd7, 0, 0);
                idle_inputs();
                rst_n = 1'b0;
                #2;
                exp_sel = 1'b0; exp_data = '0; exp_age = '0; exp_cnt = '0;
                hist.delete();
                check_model("async_reset");
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check_model("post_reset");
            end
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
